// File: rtl/unit_shop.sv
// Purchase/deploy controller: validates buy requests, issues a one-hot purchase pulse to a free Unit slot,
// owns the gold balance and enforces a post-purchase cooldown. Optional buy queueing in cooldown: SHOP_QUEUE_EN.
module unit_shop #(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned GOLD_W     = 10,
  parameter int unsigned START_GOLD = 50,
  parameter int unsigned GOLD_MAX   = 999,
  parameter int unsigned COST1      = 20,
  parameter int unsigned COST2      = 40,
  parameter int unsigned COST3      = 80,
  parameter int unsigned INCOME     = 1,
  parameter int unsigned BOUNTY     = 10,
  parameter int unsigned COOLDOWN   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gameTick,
  input  logic                 buyBtn,
  input  logic                 SW1,
  input  logic                 SW2,
  input  logic                 SW3,
  input  logic [NUM_SLOTS-1:0] slotFree,
  input  logic                 killBounty,
  output logic [NUM_SLOTS-1:0] purchase,
  output logic                 sel1,
  output logic                 sel2,
  output logic                 sel3,
  output logic [GOLD_W-1:0]    gold,
  output logic                 reject,
  output logic                 q_Idle,
  output logic                 q_Check,
  output logic                 q_Issue,
  output logic                 q_Cool
);

  localparam int unsigned CNT_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam int unsigned SUM_W = GOLD_W + 2;

  typedef enum logic [3:0] {
    QIDLE  = 4'b0001,
    QCHECK = 4'b0010,
    QISSUE = 4'b0100,
    QCOOL  = 4'b1000
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

`ifdef SHOP_QUEUE_EN
  logic       pending;
  logic [2:0] pend_sel;
`endif

  logic                 one_hot;
  logic [GOLD_W-1:0]    cost;
  logic [GOLD_W-1:0]    deduct;
  logic [NUM_SLOTS-1:0] grant;
  logic                 buy_ok;
  logic                 expire;
  logic [SUM_W-1:0]     sum;
  logic [GOLD_W-1:0]    gold_next;

  // Purchase qualification and gold update; deduction is gated by the affordability compare.
  always_comb begin
    one_hot   = ({sel1, sel2, sel3} == 3'b100) || ({sel1, sel2, sel3} == 3'b010) ||
                ({sel1, sel2, sel3} == 3'b001);
    cost      = sel1 ? GOLD_W'(COST1) : (sel2 ? GOLD_W'(COST2) : GOLD_W'(COST3));
    grant     = slotFree & (~slotFree + NUM_SLOTS'(1));
    buy_ok    = (state == QCHECK) && one_hot && (gold >= cost) && (|slotFree);
    deduct    = buy_ok ? cost : '0;
    expire    = (cnt == '0) || (gameTick && (cnt == CNT_W'(1)));
    sum       = SUM_W'(gold) - SUM_W'(deduct)
              + (gameTick   ? SUM_W'(INCOME) : '0)
              + (killBounty ? SUM_W'(BOUNTY) : '0);
    gold_next = (sum > SUM_W'(GOLD_MAX)) ? GOLD_W'(GOLD_MAX) : GOLD_W'(sum);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= QIDLE;
      gold     <= GOLD_W'(START_GOLD);
      purchase <= '0;
      sel1     <= 1'b0;
      sel2     <= 1'b0;
      sel3     <= 1'b0;
      reject   <= 1'b0;
      cnt      <= '0;
`ifdef SHOP_QUEUE_EN
      pending  <= 1'b0;
      pend_sel <= 3'b000;
`endif
    end else begin
      gold     <= gold_next;
      purchase <= '0;
      reject   <= 1'b0;
      case (state)
        QIDLE: begin
          if (buyBtn) begin
            {sel1, sel2, sel3} <= {SW1, SW2, SW3};
            state <= QCHECK;
          end
        end
        QCHECK: begin
          if (buy_ok) begin
            purchase <= grant;
            state    <= QISSUE;
          end else begin
            reject <= 1'b1;
            state  <= QIDLE;
          end
`ifndef SHOP_QUEUE_EN
          if (buyBtn) reject <= 1'b1;
`endif
        end
        QISSUE: begin
          cnt   <= CNT_W'(COOLDOWN);
          state <= QCOOL;
`ifndef SHOP_QUEUE_EN
          if (buyBtn) reject <= 1'b1;
`endif
        end
        QCOOL: begin
          if (gameTick && (cnt != '0)) cnt <= cnt - CNT_W'(1);
`ifdef SHOP_QUEUE_EN
          if (buyBtn) begin
            pending  <= 1'b1;
            pend_sel <= {SW1, SW2, SW3};
          end
          // A press on the expiry cycle itself still counts as queued.
          if (expire) begin
            if (pending || buyBtn) begin
              {sel1, sel2, sel3} <= buyBtn ? {SW1, SW2, SW3} : pend_sel;
              pending <= 1'b0;
              state   <= QCHECK;
            end else begin
              {sel1, sel2, sel3} <= 3'b000;
              state <= QIDLE;
            end
          end
`else
          if (buyBtn) reject <= 1'b1;
          if (expire) begin
            {sel1, sel2, sel3} <= 3'b000;
            state <= QIDLE;
          end
`endif
        end
        default: state <= QIDLE;
      endcase
    end
  end

  assign q_Idle  = state[0];
  assign q_Check = state[1];
  assign q_Issue = state[2];
  assign q_Cool  = state[3];

endmodule

// File: tb/tb_unit_shop.sv
// Scoreboard bench for unit_shop: expected purchase/reject events are queued at stimulus time
// and popped when the DUT pulses purchase or reject.
module tb_unit_shop;

  logic       clk = 1'b0;
  logic       reset;
  logic       gameTick, buyBtn, SW1, SW2, SW3, killBounty;
  logic [3:0] slotFree;
  logic [3:0] purchase;
  logic       sel1, sel2, sel3, reject;
  logic [9:0] gold;
  logic       q_Idle, q_Check, q_Issue, q_Cool;

  typedef struct {
    logic       rej;
    logic [3:0] pur;
    logic [9:0] g;
    logic       chk_g;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_gold;

  unit_shop dut (
    .clk(clk), .reset(reset), .gameTick(gameTick), .buyBtn(buyBtn),
    .SW1(SW1), .SW2(SW2), .SW3(SW3), .slotFree(slotFree), .killBounty(killBounty),
    .purchase(purchase), .sel1(sel1), .sel2(sel2), .sel3(sel3), .gold(gold),
    .reject(reject), .q_Idle(q_Idle), .q_Check(q_Check), .q_Issue(q_Issue), .q_Cool(q_Cool)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 999) ? 999 : v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic rej, input logic [3:0] pur, input int g, input logic chk_g);
    exp_t e;
    e.rej = rej; e.pur = pur; e.g = 10'(g); e.chk_g = chk_g;
    sb.push_back(e);
  endtask

  task automatic press(input logic [2:0] sw);
    {SW1, SW2, SW3} = sw;
    buyBtn = 1'b1;
    cyc();
    buyBtn = 1'b0;
  endtask

  task automatic tick_pulse();
    gameTick = 1'b1;
    cyc();
    gameTick = 1'b0;
    cyc();
    exp_gold = sat(exp_gold + 1);
  endtask

  task automatic bounty_pulse();
    killBounty = 1'b1;
    cyc();
    killBounty = 1'b0;
    exp_gold = sat(exp_gold + 10);
  endtask

  task automatic cool_out();
    int n = 0;
    while (!q_Idle && n < 40) begin
      tick_pulse();
      n++;
    end
    check("cool_ticks", n, 8);
  endtask

  // Scoreboard monitor: every purchase/reject pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (purchase != 4'b0000 || reject)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", int'({purchase, reject}), 0);
      end else begin
        e = sb.pop_front();
        check("sb_kind", int'(reject), int'(e.rej));
        check("sb_purchase", int'(purchase), int'(e.pur));
        if (e.chk_g) check("sb_gold", int'(gold), int'(e.g));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; gameTick = 1'b0; buyBtn = 1'b0; killBounty = 1'b0;
    {SW1, SW2, SW3} = 3'b000; slotFree = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gold", int'(gold), 50);
    check("rst_state", int'({q_Idle, q_Check, q_Issue, q_Cool}), 4'b1000);
    check("rst_outputs", int'({purchase, sel1, sel2, sel3, reject}), 0);
    reset = 1'b0;
    exp_gold = 50;
    cyc();

    // Type-1 purchase into slot 0, then full cooldown.
    push(1'b0, 4'b0001, 30, 1'b1);
    press(3'b100);
    check("t1_check_state", int'({q_Check, purchase}), 5'b10000);
    cyc();
    exp_gold = 30;
    check("t1_issue", int'({q_Issue, sel1, sel2, sel3}), 4'b1100);
    check("t1_gold", int'(gold), exp_gold);
    cyc();
    check("t1_cool", int'({q_Cool, purchase, sel1, sel2, sel3}), 8'b10000100);
    cool_out();
    check("t1_sel_clear", int'({sel1, sel2, sel3}), 0);
    check("t1_gold_after_cool", int'(gold), exp_gold);

    // Can't afford type 2.
    push(1'b1, 4'b0000, exp_gold, 1'b1);
    press(3'b010);
    cyc();
    check("t2_idle", int'(q_Idle), 1);
    cyc();
    check("t2_reject_one_cycle", int'(reject), 0);
    check("t2_gold", int'(gold), exp_gold);

    // Selection not one-hot.
    push(1'b1, 4'b0000, exp_gold, 1'b1);
    press(3'b110);
    cyc();
    cyc();
    check("t4_gold", int'(gold), exp_gold);

    // No free slot, then slot 2 free; slotFree dropping after the check must not cancel.
    repeat (5) bounty_pulse();
    slotFree = 4'b0000;
    push(1'b1, 4'b0000, exp_gold, 1'b1);
    press(3'b001);
    cyc();
    cyc();
    slotFree = 4'b0100;
    push(1'b0, 4'b0100, exp_gold - 80, 1'b1);
    press(3'b001);
    cyc();
    exp_gold = exp_gold - 80;
    check("t3_issue", int'(q_Issue), 1);
    slotFree = 4'b0000;
    cyc();
    check("t3_cool", int'(q_Cool), 1);
    slotFree = 4'hF;
    cool_out();

    // Saturation at the ceiling with tick and bounty together.
    while (exp_gold + 10 <= 995) bounty_pulse();
    while (exp_gold < 995) tick_pulse();
    check("t5_gold_995", int'(gold), 995);
    gameTick = 1'b1; killBounty = 1'b1;
    cyc();
    gameTick = 1'b0; killBounty = 1'b0;
    exp_gold = 999;
    check("t5_saturate", int'(gold), 999);

    // Reset during issue drops purchase at once and restores starting gold.
    push(1'b0, 4'b0001, 979, 1'b1);
    press(3'b100);
    cyc();
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_issue_purchase", int'(purchase), 0);
    check("rst_issue_gold", int'(gold), 50);
    check("rst_issue_state", int'(q_Idle), 1);
    cyc();
    reset = 1'b0;
    exp_gold = 50;
    cyc();

    // Deduction coinciding with income.
    push(1'b0, 4'b0001, 31, 1'b1);
    press(3'b100);
    gameTick = 1'b1;
    cyc();
    gameTick = 1'b0;
    exp_gold = 31;
    check("t5_deduct_tick", int'(gold), 31);
    cyc();

    // Buy press during cooldown.
    tick_pulse();
`ifdef SHOP_QUEUE_EN
    push(1'b0, 4'b0001, 19, 1'b1);
`else
    push(1'b1, 4'b0000, 0, 1'b0);
`endif
    press(3'b100);
    begin
      int n = 0;
      while (q_Cool && n < 40) begin
        tick_pulse();
        n++;
      end
      check("t6_cool_ticks", n + 1, 8);
    end
`ifdef SHOP_QUEUE_EN
    cyc();
    cyc();
    check("t6_queued_cool", int'(q_Cool), 1);
    check("t6_queued_gold", int'(gold), 19);
`else
    check("t6_idle", int'(q_Idle), 1);
    check("t6_gold", int'(gold), exp_gold);
`endif
    repeat (4) cyc();
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
